running_max_tree: RTL and testbench
===================================

Name: running_max_tree

Overview:
Parametrised streaming row-max unit for the softmax datapath, the generalised successor of the fixed 8-lane mode-1 max stage. Each valid beat delivers NUM_LANES floating-point values. A pipelined comparator tree reduces them to one value, and an accumulator folds successive beats into a per-row maximum plus its argmax index. Row boundaries are marked explicitly, so the unit needs no external clear. One result is emitted per row to the subtract/exp stage.

Parameters:
EXPONENT, 5, exponent field width.
MANTISSA, 10, mantissa field width.
DATAWIDTH, 16, element width; must equal EXPONENT+MANTISSA+1.
NUM_LANES, 8, elements per beat; power of two, 2..64.
PIPE_EVERY, 2, tree levels between pipeline registers; 1..log2(NUM_LANES).
IDXW, 16, argmax index width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  beat valid; no backpressure, accepted every cycle
in_last  in  1  beat is last of row; ignored when in_valid=0
in_data  in  NUM_LANES*DATAWIDTH  lane i at bits [i*DATAWIDTH +: DATAWIDTH]
out_valid  out  1  one-cycle pulse: row result valid
out_max  out  DATAWIDTH  row maximum; held between pulses
out_idx  out  IDXW  element index of row maximum; held between pulses

Behaviour:
- Reset: reset and clock are as already decided (reset reset, synchronous, active-high; clock clk). On reset, out_valid=0, out_max=0, out_idx=0, all pipeline valids=0, beat counter=0, row_start flag=1. A partially accumulated row is discarded.
- Compare rule:
  - Sign-magnitude IEEE-style compare: a>b if the signs differ and a is positive; if both are positive, a>b when mag(a)>mag(b); if both are negative, a>b when mag(a)<mag(b).
  - +0 and -0 compare equal.
  - On a tie, the lower element index wins, both in the tree and in the accumulator (earlier beat wins).
  - NaN/Inf: Inf orders naturally. NaN result is undefined and is not driven by the bench.
- Index: each lane carries index beat_cnt*NUM_LANES + lane through the tree.
  - beat_cnt increments on each accepted beat and clears after an in_last beat.
  - The index saturates at 2^IDXW-1.
- Tree: L = log2(NUM_LANES) levels. A register (data, index, valid, last) is placed after every PIPE_EVERY levels and after level L, giving P = ceil(L/PIPE_EVERY) register stages. The pipeline cannot stall.
- Accumulator stage, on tree-output valid:
  - If row_start=1: acc <= tree value/index.
  - Else: acc <= the winner of acc vs tree, with acc winning ties.
  - row_start <= tree_last.
- Output:
  - When tree-output valid and tree_last are both 1, out_max/out_idx <= the final winner (the same value the accumulator takes), and out_valid pulses the next cycle.
  - Latency: out_valid asserts exactly P+1 cycles after the in_valid&in_last sampling edge.
- Single-beat row (in_valid&in_last on the first beat): the result equals the tree result.
- Back-to-back rows: the beat after a last beat starts a fresh row with no bubble. Throughput is one beat per cycle and one row result per row.
- Gaps (in_valid=0) inside a row are allowed; the accumulator holds.
- No in_last on a beat: the row continues indefinitely and out_valid stays 0.

Test Plan:
- NUM_LANES=8, fp16: one beat {0x3C00,0x4000,0xBC00,0x3800,0,0,0,0} with last -> out_valid pulse after P+1=3 cycles, out_max=0x4000, out_idx=1.
- All-negative row, two beats: lanes 0xC000 (-2) except beat1 lane5=0xBC00 (-1) -> out_max=0xBC00, out_idx=13.
- Ties and zero: beat with 0x8000 at lane0 and 0x0000 at lane3, rest 0xC400 -> out_max=0x8000, out_idx=0. A second beat of all 0x8000 -> idx stays 0.
- Back-to-back rows: row A is a single beat with max 0x4200 at lane 2; next cycle row B is a single beat with max 0x3C00 at lane 7. Expect two pulses one cycle apart: (0x4200,2) then (0x3C00,7). Row B is not contaminated by A.
- Reset mid-row: 3 beats without last, assert reset 1 cycle, then a single-beat row with max 0x3800 at lane 4 -> out_max=0x3800, out_idx=4, no stale pulse.
- Parameter sweep NUM_LANES=16/PIPE_EVERY=1 (P=4) and NUM_LANES=2/PIPE_EVERY=1 (P=1): random rows with gaps vs reference model -> values, indices and latency P+1 all match.

Source files
------------

// File: rtl/running_max_tree.sv
// running_max_tree
// ----------------
// Streaming row-max unit. Each valid beat carries NUM_LANES sign-magnitude
// floating-point elements. A pipelined binary comparator tree reduces the beat
// to one (value, index) pair. An accumulator then folds successive beats into
// a per-row maximum and its argmax index. in_last marks the final beat of a
// row, and one result per row is emitted.
//
// Handshake: there is no backpressure. A beat is accepted on every rising edge
// where in_valid=1, and in_last is qualified by in_valid. out_valid is a
// single-cycle pulse. out_max and out_idx hold their value between pulses.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high
//   in_valid   beat valid
//   in_last    beat is the last of its row (ignored when in_valid=0)
//   in_data    lane i at bits [i*DATAWIDTH +: DATAWIDTH]
//   out_valid  one-cycle row-result pulse
//   out_max    row maximum
//   out_idx    element index of the row maximum (beat*NUM_LANES + lane, saturating)
//
// Latency: if the last beat of a row is sampled at edge s, the result
// registers load at edge s+P, where P = ceil(log2(NUM_LANES)/PIPE_EVERY).
// out_valid is therefore high during the (P+1)-th cycle counted from edge s.

module running_max_tree #(
    parameter int EXPONENT   = 5,
    parameter int MANTISSA   = 10,
    parameter int DATAWIDTH  = 16,
    parameter int NUM_LANES  = 8,
    parameter int PIPE_EVERY = 2,
    parameter int IDXW       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic                           in_last,
    input  logic [NUM_LANES*DATAWIDTH-1:0] in_data,
    output logic                           out_valid,
    output logic [DATAWIDTH-1:0]           out_max,
    output logic [IDXW-1:0]                out_idx
);

    localparam int L        = $clog2(NUM_LANES);
    localparam int SIGN_BIT = EXPONENT + MANTISSA;
    // Wide enough that beat*NUM_LANES + lane never wraps before the saturation test.
    localparam int WIDEW    = IDXW + 7;

    // Map a sign-magnitude value onto a signed integer with the same ordering.
    // Both zeros map to 0, so +0 and -0 compare equal.
    function automatic logic signed [DATAWIDTH:0] order_key(input logic [DATAWIDTH-1:0] x);
        logic signed [DATAWIDTH:0] mag;
        mag = $signed({2'b00, x[SIGN_BIT-1:0]});
        return x[SIGN_BIT] ? -mag : mag;
    endfunction

    // True only when a is strictly greater than b. Ties therefore go to b.
    function automatic logic a_beats_b(input logic [DATAWIDTH-1:0] a,
                                       input logic [DATAWIDTH-1:0] b);
        return order_key(a) > order_key(b);
    endfunction

    // ------------------------------------------------------------------
    // Beat counter and per-lane global index
    // ------------------------------------------------------------------
    logic [IDXW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDXW-1:0] lane_idx [NUM_LANES];

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (in_valid) begin
            if (in_last) begin
                beat_cnt_d = '0;
            end else if (!(&beat_cnt_q)) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_idx
        logic [WIDEW-1:0] wide;
        // NUM_LANES is a power of two, so the shift and OR equal beat*NUM_LANES + j.
        assign wide        = ({7'b0, beat_cnt_q} << L) | WIDEW'(j);
        assign lane_idx[j] = (|wide[WIDEW-1:IDXW]) ? '1 : wide[IDXW-1:0];
    end

    // ------------------------------------------------------------------
    // Comparator tree. Level 0 is the raw input. Level k has NUM_LANES>>k
    // nodes. s_* is the output seen by the next level: it is registered
    // after every PIPE_EVERY levels and after the final level, and it is a
    // plain wire otherwise.
    // ------------------------------------------------------------------
    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int N = NUM_LANES >> k;
        logic [DATAWIDTH-1:0] s_data [N];
        logic [IDXW-1:0]      s_idx  [N];
        logic                 s_valid;
        logic                 s_last;

        if (k == 0) begin : g_src
            assign s_valid = in_valid;
            assign s_last  = in_valid & in_last;
            for (genvar j = 0; j < N; j++) begin : g_lane
                assign s_data[j] = in_data[j*DATAWIDTH +: DATAWIDTH];
                assign s_idx[j]  = lane_idx[j];
            end
        end else begin : g_cmp
            logic [DATAWIDTH-1:0] c_data [N];
            logic [IDXW-1:0]      c_idx  [N];

            for (genvar j = 0; j < N; j++) begin : g_node
                // The even input always covers the lower indices. The odd
                // input must be strictly greater to win, so the lower index
                // takes ties.
                logic pick_hi;
                assign pick_hi   = a_beats_b(g_lvl[k-1].s_data[2*j+1], g_lvl[k-1].s_data[2*j]);
                assign c_data[j] = pick_hi ? g_lvl[k-1].s_data[2*j+1] : g_lvl[k-1].s_data[2*j];
                assign c_idx[j]  = pick_hi ? g_lvl[k-1].s_idx[2*j+1]  : g_lvl[k-1].s_idx[2*j];
            end

            if ((k % PIPE_EVERY == 0) || (k == L)) begin : g_reg
                always_ff @(posedge clk) begin
                    if (reset) begin
                        s_valid <= 1'b0;
                        s_last  <= 1'b0;
                    end else begin
                        s_valid <= g_lvl[k-1].s_valid;
                        s_last  <= g_lvl[k-1].s_last;
                    end
                end

                always_ff @(posedge clk) begin
                    s_data <= c_data;
                    s_idx  <= c_idx;
                end
            end else begin : g_wire
                assign s_valid = g_lvl[k-1].s_valid;
                assign s_last  = g_lvl[k-1].s_last;
                assign s_data  = c_data;
                assign s_idx   = c_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Row accumulator and result registers
    // ------------------------------------------------------------------
    logic                 t_valid, t_last;
    logic [DATAWIDTH-1:0] t_data;
    logic [IDXW-1:0]      t_idx;

    assign t_valid = g_lvl[L].s_valid;
    assign t_last  = g_lvl[L].s_last;
    assign t_data  = g_lvl[L].s_data[0];
    assign t_idx   = g_lvl[L].s_idx[0];

    logic                 row_start_q, row_start_d;
    logic [DATAWIDTH-1:0] acc_max_q, acc_max_d;
    logic [IDXW-1:0]      acc_idx_q, acc_idx_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0] out_max_q, out_max_d;
    logic [IDXW-1:0]      out_idx_q, out_idx_d;
    logic [DATAWIDTH-1:0] win_max;
    logic [IDXW-1:0]      win_idx;

    // The accumulator holds earlier beats, so it keeps ties.
    always_comb begin
        win_max = t_data;
        win_idx = t_idx;
        if (!row_start_q && !a_beats_b(t_data, acc_max_q)) begin
            win_max = acc_max_q;
            win_idx = acc_idx_q;
        end
    end

    always_comb begin
        row_start_d = row_start_q;
        acc_max_d   = acc_max_q;
        acc_idx_d   = acc_idx_q;
        out_valid_d = 1'b0;
        out_max_d   = out_max_q;
        out_idx_d   = out_idx_q;
        if (t_valid) begin
            acc_max_d   = win_max;
            acc_idx_d   = win_idx;
            row_start_d = t_last;
            if (t_last) begin
                out_valid_d = 1'b1;
                out_max_d   = win_max;
                out_idx_d   = win_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_start_q <= 1'b1;
            acc_max_q   <= '0;
            acc_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_idx_q   <= '0;
        end else begin
            row_start_q <= row_start_d;
            acc_max_q   <= acc_max_d;
            acc_idx_q   <= acc_idx_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_running_max_tree.sv
// Testbench for running_max_tree. Three instances share one input stream:
// 8 lanes / PIPE_EVERY 2 (P=2), 16 lanes / PIPE_EVERY 1 (P=4), and
// 2 lanes / PIPE_EVERY 1 (P=1). Each instance sees the low lanes of in_data.
// The reference model decodes fp16 values to real numbers and scans the
// elements in global index order, keeping the first strictly greater value.

module tb_running_max_tree;

    localparam int DW   = 16;
    localparam int IDXW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            in_valid;
    logic            in_last;
    logic [16*DW-1:0] in_data;

    logic            ov8, ov16, ov2;
    logic [DW-1:0]   om8, om16, om2;
    logic [IDXW-1:0] oi8, oi16, oi2;

    running_max_tree #(.NUM_LANES(8), .PIPE_EVERY(2)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data[8*DW-1:0]),
        .out_valid(ov8), .out_max(om8), .out_idx(oi8)
    );

    running_max_tree #(.NUM_LANES(16), .PIPE_EVERY(1)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data),
        .out_valid(ov16), .out_max(om16), .out_idx(oi16)
    );

    running_max_tree #(.NUM_LANES(2), .PIPE_EVERY(1)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data[2*DW-1:0]),
        .out_valid(ov2), .out_max(om2), .out_idx(oi2)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected entry: {due cycle[63:32], idx[31:16], max[15:0]}
    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    logic [63:0] exp_q2[$];
    logic [63:0] got8_q[$];

    real           m_best  [3];
    logic [15:0]   m_bits  [3];
    int            m_idx   [3];
    int            m_beat  [3];
    bit            m_start [3];
    logic [15:0]   last_max[3];
    logic [15:0]   last_idx[3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int nl_of(input int d);
        case (d)
            0:       return 8;
            1:       return 16;
            default: return 2;
        endcase
    endfunction

    function automatic int p_of(input int d);
        case (d)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [63:0] q_front(input int d);
        case (d)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    task automatic q_pop(input int d);
        case (d)
            0:       void'(exp_q0.pop_front());
            1:       void'(exp_q1.pop_front());
            default: void'(exp_q2.pop_front());
        endcase
    endtask

    task automatic q_push(input int d, input logic [63:0] e);
        case (d)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    // fp16 to real. Inf maps to +/-1e30. NaN is never generated.
    function automatic real fp2real(input logic [15:0] x);
        int  e;
        int  m;
        real r;
        real s;
        e = int'(x[14:10]);
        m = int'(x[9:0]);
        if (e == 31) begin
            r = 1.0e30;
        end else if (e == 0) begin
            r = real'(m) / 16777216.0;
        end else begin
            s = 1.0;
            for (int i = 0; i < e; i++) s = s * 2.0;
            r = real'(1024 + m) * s / 33554432.0;
        end
        return x[15] ? -r : r;
    endfunction

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_start[d]  = 1'b1;
            m_beat[d]   = 0;
            m_best[d]   = 0.0;
            m_bits[d]   = '0;
            m_idx[d]    = 0;
            last_max[d] = '0;
            last_idx[d] = '0;
        end
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        got8_q.delete();
    endtask

    task automatic model_beat(input int d);
        int nl;
        nl = nl_of(d);
        if (!in_valid) return;
        for (int ln = 0; ln < nl; ln++) begin
            logic [15:0] x;
            real         r;
            int          gi;
            x  = in_data[ln*16 +: 16];
            r  = fp2real(x);
            gi = m_beat[d] * nl + ln;
            if (gi > 65535) gi = 65535;
            if (m_start[d] || r > m_best[d]) begin
                m_best[d]  = r;
                m_bits[d]  = x;
                m_idx[d]   = gi;
                m_start[d] = 1'b0;
            end
        end
        if (in_last) begin
            // Due at the edge P+1 edges on, counting the sampling edge as the first.
            q_push(d, {32'(cyc + p_of(d) + 1), 16'(m_idx[d]), m_bits[d]});
            m_start[d] = 1'b1;
            m_beat[d]  = 0;
        end else begin
            m_beat[d] = m_beat[d] + 1;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_dut(input int d);
        logic        v;
        logic [15:0] mx;
        logic [15:0] ix;
        logic [63:0] e;
        case (d)
            0:       begin v = ov8;  mx = om8;  ix = oi8;  end
            1:       begin v = ov16; mx = om16; ix = oi16; end
            default: begin v = ov2;  mx = om2;  ix = oi2;  end
        endcase
        if (v) begin
            if (q_size(d) == 0) begin
                check($sformatf("dut%0d_spurious_pulse", d), 64'd1, 64'd0);
            end else begin
                e = q_front(d);
                q_pop(d);
                check($sformatf("dut%0d_max", d), 64'(mx), 64'(e[15:0]));
                check($sformatf("dut%0d_idx", d), 64'(ix), 64'(e[31:16]));
                check($sformatf("dut%0d_latency", d), 64'(cyc), 64'(e[63:32]));
                last_max[d] = e[15:0];
                last_idx[d] = e[31:16];
            end
        end else begin
            check($sformatf("dut%0d_hold_max", d), 64'(mx), 64'(last_max[d]));
            check($sformatf("dut%0d_hold_idx", d), 64'(ix), 64'(last_idx[d]));
            if (q_size(d) > 0) begin
                e = q_front(d);
                if (int'(e[63:32]) < cyc) begin
                    check($sformatf("dut%0d_missing_pulse", d), 64'd0, 64'd1);
                    q_pop(d);
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic last, input logic [255:0] d);
        in_valid = v;
        in_last  = last;
        in_data  = d;
        for (int k = 0; k < 3; k++) model_beat(k);
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < 3; k++) check_dut(k);
        if (ov8) got8_q.push_back({32'(cyc), oi8, om8});
    endtask

    // Idle cycles drive junk data and a random in_last, which must be ignored.
    task automatic idle(input int n);
        logic [255:0] junk;
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < 8; w++) junk[w*32 +: 32] = $urandom;
            step(1'b0, 1'($urandom_range(0, 1)), junk);
        end
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            check("reset_ov8", 64'(ov8), 64'd0);
            check("reset_om8", 64'(om8), 64'd0);
            check("reset_oi8", 64'(oi8), 64'd0);
            check("reset_ov16", 64'(ov16), 64'd0);
            check("reset_om2", 64'(om2), 64'd0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic take8(input string tag, output logic [63:0] g);
        if (got8_q.size() == 0) begin
            check({tag, "_no_pulse"}, 64'd0, 64'd1);
            g = '0;
        end else begin
            g = got8_q.pop_front();
        end
    endtask

    function automatic logic [255:0] fill(input logic [15:0] v);
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [15:0] rand_fp();
        logic [15:0] pool [4];
        pool[0] = 16'h3C00;
        pool[1] = 16'hBC00;
        pool[2] = 16'h4000;
        pool[3] = 16'hC000;
        case ($urandom_range(0, 9))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'h7C00;
            3:       return 16'hFC00;
            4, 5:    return pool[$urandom_range(0, 3)];
            default: return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom)};
        endcase
    endfunction

    function automatic logic [255:0] rand_data();
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = rand_fp();
        return r;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] d;
        logic [255:0] d2;
        logic [63:0]  g;
        logic [63:0]  g2;
        int           t0;
        int           nb;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        model_reset();
        do_reset(3);

        // Single beat row: expect max 0x4000 at lane 1, pulse on the 3rd edge.
        d = '0;
        d[0*16 +: 16] = 16'h3C00;
        d[1*16 +: 16] = 16'h4000;
        d[2*16 +: 16] = 16'hBC00;
        d[3*16 +: 16] = 16'h3800;
        t0 = cyc;
        step(1'b1, 1'b1, d);
        idle(6);
        check("t1_pulse_count", 64'(got8_q.size()), 64'd1);
        take8("t1", g);
        check("t1_max", 64'(g[15:0]), 64'h4000);
        check("t1_idx", 64'(g[31:16]), 64'd1);
        check("t1_latency", 64'(int'(g[63:32]) - t0), 64'd3);

        // All-negative two-beat row.
        d = fill(16'hC000);
        step(1'b1, 1'b0, d);
        d[5*16 +: 16] = 16'hBC00;
        step(1'b1, 1'b1, d);
        idle(6);
        take8("t2", g);
        check("t2_max", 64'(g[15:0]), 64'hBC00);
        check("t2_idx", 64'(g[31:16]), 64'd13);

        // -0 at lane 0 ties +0 at lane 3. The lower index wins.
        d = fill(16'hC400);
        d[0*16 +: 16] = 16'h8000;
        d[3*16 +: 16] = 16'h0000;
        step(1'b1, 1'b1, d);
        idle(5);
        take8("t3a", g);
        check("t3a_max", 64'(g[15:0]), 64'h8000);
        check("t3a_idx", 64'(g[31:16]), 64'd0);
        // The earlier beat keeps a tie against the later all -0 beat.
        step(1'b1, 1'b0, d);
        step(1'b1, 1'b1, fill(16'h8000));
        idle(5);
        take8("t3b", g);
        check("t3b_max", 64'(g[15:0]), 64'h8000);
        check("t3b_idx", 64'(g[31:16]), 64'd0);

        // Back-to-back single-beat rows.
        d = fill(16'h3000);
        d[2*16 +: 16] = 16'h4200;
        d2 = fill(16'hB000);
        d2[7*16 +: 16] = 16'h3C00;
        step(1'b1, 1'b1, d);
        step(1'b1, 1'b1, d2);
        idle(6);
        check("t4_pulse_count", 64'(got8_q.size()), 64'd2);
        take8("t4a", g);
        take8("t4b", g2);
        check("t4a_max", 64'(g[15:0]), 64'h4200);
        check("t4a_idx", 64'(g[31:16]), 64'd2);
        check("t4b_max", 64'(g2[15:0]), 64'h3C00);
        check("t4b_idx", 64'(g2[31:16]), 64'd7);
        check("t4_spacing", 64'(int'(g2[63:32]) - int'(g[63:32])), 64'd1);

        // Reset mid-row discards the partial row.
        d = fill(16'h2000);
        d[0*16 +: 16] = 16'h7000;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, d);
        do_reset(1);
        d = fill(16'h2000);
        d[4*16 +: 16] = 16'h3800;
        step(1'b1, 1'b1, d);
        idle(6);
        check("t5_pulse_count", 64'(got8_q.size()), 64'd1);
        take8("t5", g);
        check("t5_max", 64'(g[15:0]), 64'h3800);
        check("t5_idx", 64'(g[31:16]), 64'd4);

        // Random rows with gaps and back-to-back rows.
        for (int r = 0; r < 300; r++) begin
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                step(1'b1, 1'(b == nb - 1), rand_data());
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(6);
        got8_q.delete();

        // Long row: the index saturates for 8 and 16 lanes, and the row
        // produces no pulse until its last beat.
        for (int b = 0; b < 8199; b++) begin
            for (int i = 0; i < 16; i++)
                d[i*16 +: 16] = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 29)), 10'($urandom)};
            step(1'b1, 1'b0, d);
        end
        check("t6_no_early_pulse", 64'(got8_q.size()), 64'd0);
        d = fill(16'h3000);
        d[0] = 1'b0;
        d[0*16 +: 16] = 16'h7BFF;
        step(1'b1, 1'b1, d);
        idle(6);
        take8("t6", g);
        check("t6_max", 64'(g[15:0]), 64'h7BFF);
        check("t6_idx_saturated", 64'(g[31:16]), 64'hFFFF);

        idle(8);
        for (int k = 0; k < 3; k++)
            check($sformatf("dut%0d_drain", k), 64'(q_size(k)), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
